// File: rtl/seg_scan_ctrl.sv
// Multiplexed N-digit 7-segment scan controller: bank select, per-frame snapshot,
// one-hot digit scan, per-digit blink and PWM anode dimming.
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 17,
    parameter int unsigned PWM_BITS   = 3,
    parameter int unsigned BLINK_DIV  = 25
) (
    input  logic                      clk,
    input  logic                      reset_,
    input  logic [4*NUM_DIGITS-1:0]   digits_a,
    input  logic [4*NUM_DIGITS-1:0]   digits_b,
    input  logic                      sel_b,
    input  logic                      blink_en,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [PWM_BITS-1:0]       brightness,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [7:0]                catod,
    output logic                      frame_tick
);

    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned ON_W  = PWM_BITS + 1 + CNT_W;
    localparam int unsigned DIG_W = 4 * NUM_DIGITS;

    logic [CNT_W-1:0]      slot_cnt;
    logic [IDX_W-1:0]      idx;
    logic [BLK_W-1:0]      blink_cnt;
    logic                  blink_phase;   // 1 = hidden
    logic                  load_pending;
    logic [DIG_W-1:0]      snap_digits;
    logic [NUM_DIGITS-1:0] snap_mask;
    logic [NUM_DIGITS-1:0] snap_dp;
    logic [PWM_BITS-1:0]   bri_q;

    logic                  slot_last_c;
    logic                  idx_last_c;
    logic                  eof_c;
    logic [ON_W-1:0]       on_cycles_c;
    logic [3:0]            cur_digit_c;
    logic                  blank_c;
    logic                  lit_c;
    logic [NUM_DIGITS-1:0] an_nxt_c;
    logic [7:0]            catod_nxt_c;

    function automatic logic [6:0] seg_decode(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Scan position, PWM window and next registered pin values
    always_comb begin
        slot_last_c = (slot_cnt == CNT_W'(SCAN_DIV - 1));
        idx_last_c  = (idx == IDX_W'(NUM_DIGITS - 1));
        eof_c       = slot_last_c && idx_last_c;
        on_cycles_c = ON_W'(((ON_W'(bri_q) + ON_W'(1)) * ON_W'(SCAN_DIV - 1)) >> PWM_BITS);
        cur_digit_c = snap_digits[{idx, 2'b00} +: 4];
        blank_c     = blink_en && blink_phase && snap_mask[idx];
        lit_c       = (slot_cnt != '0) && (ON_W'(slot_cnt) <= on_cycles_c) && !blank_c;
        an_nxt_c    = '1;
        catod_nxt_c = 8'hFF;
        if (lit_c) begin
            an_nxt_c    = ~(NUM_DIGITS'(1) << idx);
            catod_nxt_c = {~snap_dp[idx], seg_decode(cur_digit_c)};
        end
    end

    always_ff @(posedge clk) begin
        if (reset_) begin
            slot_cnt     <= '0;
            idx          <= '0;
            blink_cnt    <= '0;
            blink_phase  <= 1'b0;
            load_pending <= 1'b1;
            snap_digits  <= '0;
            snap_mask    <= '0;
            snap_dp      <= '0;
            bri_q        <= '0;
            an           <= '1;
            catod        <= 8'hFF;
            frame_tick   <= 1'b0;
        end else begin
            slot_cnt <= slot_last_c ? '0 : slot_cnt + CNT_W'(1);
            if (slot_last_c) begin
                idx <= idx_last_c ? '0 : idx + IDX_W'(1);
            end
            frame_tick <= eof_c;

            // Tear-free: display content only changes at frame boundaries
            if (eof_c || load_pending) begin
                snap_digits  <= sel_b ? digits_b : digits_a;
                snap_mask    <= blink_mask;
                snap_dp      <= dp_in;
                load_pending <= 1'b0;
            end

            if (eof_c) begin
                if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BLK_W'(1);
                end
            end

            if (slot_cnt == '0) begin
                bri_q <= brightness;
            end

            an    <= an_nxt_c;
            catod <= catod_nxt_c;
        end
    end

endmodule
